// File: rtl/aux_run_ctrl_if.sv
// Control/status bundle between the run controller and the core-side logic.
// The master drives the button, mode and core status; the slave returns enable and run status.
interface aux_run_ctrl_if #(
    parameter int StepBit = 16
);
    logic               resume;
    logic [1:0]         mode;
    logic [StepBit-1:0] step_n;
    logic [31:0]        bp_addr;
    logic [31:0]        pc;
    logic               halt;
    logic               en;
    logic               running;
    logic [2:0]         cause;
    logic [StepBit-1:0] steps_done;

    modport master (
        output resume, mode, step_n, bp_addr, pc, halt,
        input  en, running, cause, steps_done
    );

    modport slave (
        input  resume, mode, step_n, bp_addr, pc, halt,
        output en, running, cause, steps_done
    );
endinterface

// File: rtl/aux_run_ctrl.sv
// Run/step/breakpoint controller: debounces the resume button and gates the core
// clock-enable for free run, single step, N-step and run-to-breakpoint.
module aux_run_ctrl #(
    parameter logic [15:0] DebounceMax = 16'd1000,
    parameter int          StepBit     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    aux_run_ctrl_if.slave bus
);
    typedef enum logic {
        ST_PAUSE,
        ST_RUN
    } state_t;

    localparam logic [2:0] CAUSE_RESET = 3'd0;
    localparam logic [2:0] CAUSE_USER  = 3'd1;
    localparam logic [2:0] CAUSE_HALT  = 3'd2;
    localparam logic [2:0] CAUSE_STEP  = 3'd3;
    localparam logic [2:0] CAUSE_BP    = 3'd4;

    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_NSTEP = 2'b10;
    localparam logic [1:0] MODE_BP    = 2'b11;

    localparam logic [StepBit-1:0] ONE      = StepBit'(1);
    localparam logic [StepBit-1:0] ALL_ONES = '1;

    // ---------------- button synchronizer and debounce ----------------
    logic        sync1_reg;
    logic        sync2_reg;
    logic        level_reg;
    logic        go_reg;
    logic [15:0] db_cnt_reg;
    logic        differ;
    logic        settle;

    assign differ = (sync2_reg != level_reg);
    assign settle = differ && (db_cnt_reg >= (DebounceMax - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            level_reg  <= 1'b0;
            go_reg     <= 1'b0;
            db_cnt_reg <= 16'd0;
        end else begin
            sync1_reg <= bus.resume;
            sync2_reg <= sync1_reg;
            go_reg    <= 1'b0;
            if (!differ) begin
                db_cnt_reg <= 16'd0;
            end else if (settle) begin
                level_reg  <= sync2_reg;
                db_cnt_reg <= 16'd0;
                // only the press edge produces an event; release is silent
                go_reg     <= sync2_reg;
            end else begin
                db_cnt_reg <= db_cnt_reg + 16'd1;
            end
        end
    end

    // ---------------- run/pause state machine ----------------
    state_t             state_reg,      state_next;
    logic [1:0]         mode_reg,       mode_next;
    logic [StepBit-1:0] budget_reg,     budget_next;
    logic               first_reg,      first_next;
    logic [StepBit-1:0] steps_done_reg, steps_done_next;
    logic [2:0]         cause_reg,      cause_next;

    logic running;
    logic step_mode;
    logic bp_hit;
    logic halt_hit;
    logic en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_PAUSE;
            mode_reg       <= 2'b00;
            budget_reg     <= '0;
            first_reg      <= 1'b0;
            steps_done_reg <= '0;
            cause_reg      <= CAUSE_RESET;
        end else begin
            state_reg      <= state_next;
            mode_reg       <= mode_next;
            budget_reg     <= budget_next;
            first_reg      <= first_next;
            steps_done_reg <= steps_done_next;
            cause_reg      <= cause_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        mode_next       = mode_reg;
        budget_next     = budget_reg;
        first_next      = first_reg;
        steps_done_next = steps_done_reg;
        cause_next      = cause_reg;

        running   = (state_reg == ST_RUN);
        step_mode = (mode_reg == MODE_STEP) || (mode_reg == MODE_NSTEP);
        // 'first' lets a fresh press execute past a halt or a PC already on the breakpoint
        bp_hit    = running && (mode_reg == MODE_BP) && (bus.pc == bus.bp_addr) && !first_reg;
        halt_hit  = running && bus.halt && !first_reg;
        en        = running && !halt_hit && !bp_hit;

        case (state_reg)
            ST_PAUSE: begin
                if (go_reg) begin
                    state_next      = ST_RUN;
                    mode_next       = bus.mode;
                    first_next      = 1'b1;
                    steps_done_next = '0;
                    if (bus.mode == MODE_NSTEP && bus.step_n != '0) begin
                        budget_next = bus.step_n;
                    end else begin
                        budget_next = ONE;
                    end
                end
            end
            ST_RUN: begin
                first_next = 1'b0;
                if (en) begin
                    if (steps_done_reg != ALL_ONES) begin
                        steps_done_next = steps_done_reg + ONE;
                    end
                    if (step_mode) begin
                        budget_next = budget_reg - ONE;
                    end
                end
                // a press coinciding with a higher-priority stop is simply consumed
                if (halt_hit) begin
                    state_next = ST_PAUSE;
                    cause_next = CAUSE_HALT;
                end else if (bp_hit) begin
                    state_next = ST_PAUSE;
                    cause_next = CAUSE_BP;
                end else if (step_mode && budget_reg == ONE) begin
                    state_next = ST_PAUSE;
                    cause_next = CAUSE_STEP;
                end else if (go_reg) begin
                    state_next = ST_PAUSE;
                    cause_next = CAUSE_USER;
                end
            end
            default: begin
                state_next = ST_PAUSE;
            end
        endcase
    end

    assign bus.en         = en;
    assign bus.running    = running;
    assign bus.cause      = cause_reg;
    assign bus.steps_done = steps_done_reg;
endmodule

// File: doc/aux_run_ctrl.md
# aux_run_ctrl

Run/step/breakpoint controller for the processor core on the FPGA top level. It debounces the `resume` push-button and produces the core clock-enable `en`. It supports free run, single step, N-step and run-to-breakpoint. It pauses on core halt, step exhaustion, breakpoint hit or a user press. It sits in the core clock domain, feeding `en` to the core and to every performance counter.

## Interface
Parameters:
- `DebounceMax`, default 16'd1000: consecutive stable synchronized samples required to accept a button level change.
- `StepBit`, default 16: width of the step budget and of the executed-cycle counter.

Ports:
- `clk` in 1: core clock. The only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `resume` in 1: raw push-button, active high, asynchronous to `clk`.
- `mode` in 2: run mode, sampled only at an accepted press. 00 free run, 01 single step, 10 N-step, 11 run-to-breakpoint.
- `step_n` in StepBit: N for mode 10. A value of 0 is treated as 1.
- `bp_addr` in 32: breakpoint PC for mode 11.
- `pc` in 32: current core PC.
- `halt` in 1: core halt request (halt syscall at current PC).
- `en` out 1: core/counter enable.
- `running` out 1: state == RUN.
- `cause` out 3: reason for the last pause. 0 RESET, 1 USER, 2 HALT, 3 STEP, 4 BP.
- `steps_done` out StepBit: enabled cycles since the last accepted press.

## Operation
- **Button path**
  - 2-flop synchronizer, then a debounce counter.
  - The debounced level changes only after `DebounceMax` consecutive samples differ from it. Any intermediate sample equal to the current level clears the counter.
  - `go` is a registered 1-cycle pulse on the debounced 0->1 transition. Release generates nothing.
- **States:** PAUSE (reset state) and RUN. Registers: `mode_q`, `budget`, `first`, `steps_done`, `cause`.
- **PAUSE, on `go`:**
  - Go to RUN and latch `mode_q <= mode`.
  - `budget <=` 1 (mode 01), `max(step_n,1)` (mode 10), don't-care otherwise.
  - `first <= 1`, `steps_done <= 0`.
- **RUN combinational terms:**
  - `bp_hit = (mode_q==11) && (pc==bp_addr) && !first`
  - `halt_hit = halt && !first`
  - `en = running && !halt_hit && !bp_hit`
- **RUN transitions.** Evaluated each cycle in priority order; the first match wins:
  1. `halt_hit` -> PAUSE, cause HALT.
  2. `bp_hit` -> PAUSE, cause BP.
  3. Step mode (01/10) and `budget==1` -> PAUSE, cause STEP. This cycle's `en` is still 1.
  4. `go` -> PAUSE, cause USER. This cycle's `en` is still 1.
  5. Otherwise stay in RUN.
- **Every RUN cycle with `en=1`:**
  - `steps_done` increments, saturating at all-ones.
  - In step modes, `budget` decrements.
  - `first` clears after the first RUN cycle regardless of `en`.
- **`first` purpose:** lets a press resume past a still-asserted `halt` or a PC sitting on `bp_addr`. That instruction executes once.
- **Stability rules:**
  - `mode`, `step_n` and `bp_addr` changes during RUN have no effect; `bp_addr` is compared live, so software must hold it stable.
  - `cause` and `steps_done` hold their values in PAUSE until the next `go`.
- **Reset (any time, including mid-RUN or mid-debounce):**
  - State PAUSE; `en=0`, `running=0`, `cause=0`, `steps_done=0`.
  - Synchronizer, debounced level and debounce counter cleared.
  - A button held through reset release is accepted only after `DebounceMax` stable cycles.

## Timing
- Press latency: `resume` rise stable at cycle t -> `go` high in cycle t+2+`DebounceMax`±1. `running` and `en` high the cycle after `go`.
- Single step: exactly 1 `en` cycle per accepted press.
- N-step: exactly N consecutive `en` cycles unless pre-empted by halt or breakpoint.
- Halt or breakpoint gating of `en` is same-cycle (combinational). The state leaves RUN at the next edge.
- `go` in the same cycle as a higher-priority stop: cause reflects the higher priority, and the press is consumed (no re-run).

## Test plan
- **Debounce:** `DebounceMax=4`; bounce `resume` 1,0,1,0 each 1 cycle, then hold 1 for 10 cycles -> exactly one `go`, `running=1` at cycle ~8 after the stable edge; release generates no event.
- **Single step:** mode 01, 3 presses -> `en` high for exactly 3 isolated cycles, `steps_done=1` after each, `cause=3`.
- **N-step:** mode 10, `step_n=5` -> 5 contiguous `en` cycles, `steps_done=5`, `cause=3`. `step_n=0` -> 1 cycle.
- **Breakpoint:** mode 11, `bp_addr=0x0000_0010`, pc counts up by 4 from 0 -> `en` high for pcs 0,4,8,C, low at 0x10, `cause=4`, `steps_done=4`. Next press executes 0x10 and continues.
- **Halt priority:** free run; assert `halt` and `go` in the same cycle -> PAUSE, `cause=2`. Press again with `halt` still high -> one `en` cycle, then PAUSE `cause=2`.
- **Reset mid-RUN:** assert `rst_n=0` while `en=1`, `steps_done=37` -> `en`, `running`, `cause`, `steps_done` all 0 immediately (asynchronous); resume held through reset needs the full debounce.
